// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
// State encoding, port indices and parameter defaults live here so all files agree.
package sdram_arbiter_pkg;

  localparam int unsigned DEFAULT_ADDR_W  = 23;
  localparam int unsigned DEFAULT_TIMEOUT = 1023;
  localparam int unsigned TMO_W           = 10;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of requester ports, controller command/response signals and the error pulse.
// The master modport is the arbiter's view; slave is the requesters' and controller's view.
interface sdram_arbiter_if
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) ();

  logic              p0_rd;
  logic              p0_wr;
  logic [ADDR_W-1:0] p0_addr;
  logic [15:0]       p0_wdata;
  logic [31:0]       p0_rdata;
  logic              p0_done;
  logic              p0_busy;

  logic              p1_rd;
  logic              p1_wr;
  logic [ADDR_W-1:0] p1_addr;
  logic [15:0]       p1_wdata;
  logic [31:0]       p1_rdata;
  logic              p1_done;
  logic              p1_busy;

  logic              sd_read;
  logic              sd_write;
  logic [ADDR_W-1:0] sd_addr;
  logic [15:0]       sd_wdata;
  logic              sd_busy;
  logic              sd_cack;
  logic              sd_ready;
  logic [31:0]       sd_rdata;

  logic              err;

  modport master (
    input  p0_rd, p0_wr, p0_addr, p0_wdata,
    input  p1_rd, p1_wr, p1_addr, p1_wdata,
    input  sd_busy, sd_cack, sd_ready, sd_rdata,
    output p0_rdata, p0_done, p0_busy,
    output p1_rdata, p1_done, p1_busy,
    output sd_read, sd_write, sd_addr, sd_wdata,
    output err
  );

  modport slave (
    output p0_rd, p0_wr, p0_addr, p0_wdata,
    output p1_rd, p1_wr, p1_addr, p1_wdata,
    output sd_busy, sd_cack, sd_ready, sd_rdata,
    input  p0_rdata, p0_done, p0_busy,
    input  p1_rdata, p1_done, p1_busy,
    input  sd_read, sd_write, sd_addr, sd_wdata,
    input  err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant: a lone requester always wins, a tie goes to the pointer.
module rr_arbiter2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       rr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = rr ? 2'b10 : 2'b01;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates a CPU and a DMA requester onto one SDRAM controller, one access in flight,
// with round-robin fairness and an access timeout that aborts with an error pulse.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic             clki,
  input logic             rst_in,
  sdram_arbiter_if.master bus
);

  state_e             state;
  op_e                op;
  logic               rr;
  logic               gnt_port;
  logic [31:0]        cap;
  logic [TMO_W-1:0]   tmo_cnt;

  logic               req0;
  logic               req1;
  logic [1:0]         gnt;
  logic               gnt_idx;
  logic               gnt_wr;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [15:0]        gnt_wdata;
  logic               tmo_hit;
  logic               finish;
  logic               abort;

  // Busy drops while done shows, which also keeps a held request from being re-granted
  // in its own done cycle.
  assign bus.p0_busy = (bus.p0_rd | bus.p0_wr) & ~bus.p0_done;
  assign bus.p1_busy = (bus.p1_rd | bus.p1_wr) & ~bus.p1_done;
  assign req0        = bus.p0_busy;
  assign req1        = bus.p1_busy;

  rr_arbiter2 u_rr_arbiter2 (
    .req0 (req0),
    .req1 (req1),
    .rr   (rr),
    .gnt  (gnt)
  );

  always_comb begin
    gnt_idx   = PORT_CPU;
    gnt_wr    = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    unique case (gnt)
      2'b01: begin
        gnt_idx   = PORT_CPU;
        gnt_wr    = bus.p0_wr;
        gnt_addr  = bus.p0_addr;
        gnt_wdata = bus.p0_wdata;
      end
      2'b10: begin
        gnt_idx   = PORT_DMA;
        gnt_wr    = bus.p1_wr;
        gnt_addr  = bus.p1_addr;
        gnt_wdata = bus.p1_wdata;
      end
      default: ;
    endcase
  end

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // A normal completion in the same cycle as the timeout wins over the abort.
  always_comb begin
    finish = 1'b0;
    abort  = 1'b0;
    if (state == StIssue) begin
      finish = bus.sd_cack & bus.sd_ready;
    end else if (state == StWait) begin
      finish = bus.sd_ready;
    end
    if (state == StIssue || state == StWait) begin
      abort = tmo_hit & ~finish;
    end
  end

  always_ff @(posedge clki or negedge rst_in) begin
    if (!rst_in) begin
      state        <= StIdle;
      op           <= OpRead;
      rr           <= PORT_CPU;
      gnt_port     <= PORT_CPU;
      cap          <= '0;
      tmo_cnt      <= '0;
      bus.sd_read  <= 1'b0;
      bus.sd_write <= 1'b0;
      bus.sd_addr  <= '0;
      bus.sd_wdata <= '0;
      bus.p0_rdata <= '0;
      bus.p1_rdata <= '0;
      bus.p0_done  <= 1'b0;
      bus.p1_done  <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.p0_done <= 1'b0;
      bus.p1_done <= 1'b0;
      bus.err     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!bus.sd_busy && gnt != 2'b00) begin
            gnt_port     <= gnt_idx;
            rr           <= ~gnt_idx;
            op           <= gnt_wr ? OpWrite : OpRead;
            bus.sd_addr  <= gnt_addr;
            bus.sd_wdata <= gnt_wdata;
            bus.sd_read  <= ~gnt_wr;
            bus.sd_write <= gnt_wr;
            tmo_cnt      <= '0;
            state        <= StIssue;
          end
        end
        StIssue: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.sd_cack) begin
            bus.sd_read  <= 1'b0;
            bus.sd_write <= 1'b0;
            if (bus.sd_ready) begin
              cap   <= bus.sd_rdata;
              state <= StDone;
            end else begin
              state <= StWait;
            end
          end
        end
        StWait: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.sd_ready) begin
            cap   <= bus.sd_rdata;
            state <= StDone;
          end
        end
        StDone: begin
          state <= StIdle;
          if (gnt_port == PORT_DMA) begin
            bus.p1_done <= 1'b1;
            if (op == OpRead) bus.p1_rdata <= cap;
          end else begin
            bus.p0_done <= 1'b1;
            if (op == OpRead) bus.p0_rdata <= cap;
          end
        end
        default: state <= StIdle;
      endcase

      if (abort) begin
        bus.sd_read  <= 1'b0;
        bus.sd_write <= 1'b0;
        bus.err      <= 1'b1;
        state        <= StIdle;
        if (gnt_port == PORT_DMA) begin
          bus.p1_done  <= 1'b1;
          bus.p1_rdata <= '0;
        end else begin
          bus.p0_done  <= 1'b1;
          bus.p0_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a controller model answers strobes, and scoreboards
// hold the expected command stream and done/err events.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int unsigned AW  = 23;
  localparam int unsigned TMO = 1023;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
  } cmd_t;

  typedef struct {
    logic        port;
    logic        err;
    logic        upd;
    logic [31:0] rdata;
  } done_t;

  logic clki = 1'b0;
  logic rst_in;
  always #5 clki = ~clki;

  sdram_arbiter_if #(.ADDR_W(AW)) bus ();

  sdram_arbiter #(
    .ADDR_W  (AW),
    .TIMEOUT (TMO)
  ) dut (
    .clki   (clki),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          ndone    = 0;
  cmd_t        exp_cmd[$];
  done_t       exp_done[$];
  cmd_t        mon_c;
  done_t       mon_e;
  logic [31:0] shadow0  = '0;
  logic [31:0] shadow1  = '0;
  int          mode     = 0;   // 0: cack+ready at once, 1: ready 3 cycles after cack, 2: never ready
  logic [31:0] ctl_rdata = '0;
  int          slow_cnt = 0;
  logic        prev_strobe = 1'b0;
  int          cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic wr, input logic [AW-1:0] addr, input logic [15:0] wdata);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata;
    exp_cmd.push_back(c);
  endtask

  task automatic push_done(input logic port, input logic err, input logic upd,
                           input logic [31:0] rdata);
    done_t d;
    d.port = port; d.err = err; d.upd = upd; d.rdata = rdata;
    exp_done.push_back(d);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic wait_ndone(input int target, input int budget, input string tag);
    int n = 0;
    while (ndone < target && n < budget) begin
      @(negedge clki);
      #1;
      n++;
    end
    checks++;
    assert (ndone >= target) else begin
      failures++;
      $error("FAIL %s_timeout observed_done=%0d expected_done=%0d", tag, ndone, target);
    end
  endtask

  // Controller model: decisions made on the falling edge, sampled by the DUT on the rising edge.
  always @(negedge clki) begin
    bus.sd_cack  = 1'b0;
    bus.sd_ready = 1'b0;
    if (!rst_in) begin
      slow_cnt = 0;
    end else if (bus.sd_read || bus.sd_write) begin
      bus.sd_cack = 1'b1;
      if (mode == 0) begin
        bus.sd_ready = 1'b1;
        bus.sd_rdata = ctl_rdata;
      end else if (mode == 1) begin
        slow_cnt = 3;
      end
    end else if (slow_cnt != 0) begin
      slow_cnt--;
      if (slow_cnt == 0) begin
        bus.sd_ready = 1'b1;
        bus.sd_rdata = ctl_rdata;
      end
    end
  end

  // Command scoreboard: each new strobe must match the next expected command.
  always @(negedge clki) begin
    if (rst_in && (bus.sd_read || bus.sd_write) && !prev_strobe) begin
      checks++;
      assert (exp_cmd.size() != 0) else begin
        failures++;
        $error("FAIL cmd_unexpected observed addr=%0h expected no command", bus.sd_addr);
      end
      if (exp_cmd.size() != 0) begin
        mon_c = exp_cmd.pop_front();
        chk("cmd_write", 64'(bus.sd_write), 64'(mon_c.wr));
        chk("cmd_read", 64'(bus.sd_read), 64'(!mon_c.wr));
        chk("cmd_addr", 64'(bus.sd_addr), 64'(mon_c.addr));
        chk("cmd_wdata", 64'(bus.sd_wdata), 64'(mon_c.wdata));
      end
    end
    prev_strobe = bus.sd_read | bus.sd_write;
  end

  // Completion scoreboard: done/err pulses and both ports' read data.
  always @(negedge clki) begin
    if (rst_in && (bus.p0_done || bus.p1_done || bus.err)) begin
      checks++;
      assert (exp_done.size() != 0) else begin
        failures++;
        $error("FAIL done_unexpected observed p0=%b p1=%b err=%b expected none",
               bus.p0_done, bus.p1_done, bus.err);
      end
      if (exp_done.size() != 0) begin
        mon_e = exp_done.pop_front();
        chk("done_port", 64'({bus.p1_done, bus.p0_done}), mon_e.port ? 64'd2 : 64'd1);
        chk("err_pulse", 64'(bus.err), 64'(mon_e.err));
        if (mon_e.upd) begin
          if (mon_e.port) shadow1 = mon_e.rdata;
          else shadow0 = mon_e.rdata;
        end
        chk("p0_rdata", 64'(bus.p0_rdata), 64'(shadow0));
        chk("p1_rdata", 64'(bus.p1_rdata), 64'(shadow1));
      end
      ndone++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in       = 1'b0;
    bus.p0_rd    = 1'b0; bus.p0_wr = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_rd    = 1'b0; bus.p1_wr = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    bus.sd_busy  = 1'b0; bus.sd_cack = 1'b0; bus.sd_ready = 1'b0; bus.sd_rdata = '0;
    cyc(3);
    chk("rst_sd_read", 64'(bus.sd_read), 64'd0);
    chk("rst_sd_write", 64'(bus.sd_write), 64'd0);
    chk("rst_sd_addr", 64'(bus.sd_addr), 64'd0);
    chk("rst_p0_rdata", 64'(bus.p0_rdata), 64'd0);
    chk("rst_p0_done", 64'(bus.p0_done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    rst_in = 1'b1;
    cyc(1);

    // Single CPU read at minimum latency.
    mode = 0; ctl_rdata = 32'hDEADBEEF;
    bus.p0_addr = 23'h000100; bus.p0_wdata = 16'h5A5A; bus.p0_rd = 1'b1;
    push_cmd(1'b0, 23'h000100, 16'h5A5A);
    push_done(PORT_CPU, 1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clki);
    chk("t1_busy", 64'(bus.p0_busy), 64'd1);
    chk("t1_no_strobe_yet", 64'(bus.sd_read), 64'd0);
    @(negedge clki);
    chk("t1_strobe", 64'(bus.sd_read), 64'd1);
    @(negedge clki);
    chk("t1_strobe_low", 64'(bus.sd_read), 64'd0);
    chk("t1_done_not_yet", 64'(bus.p0_done), 64'd0);
    @(negedge clki);
    chk("t1_done", 64'(bus.p0_done), 64'd1);
    chk("t1_busy_in_done", 64'(bus.p0_busy), 64'd0);
    chk("t1_p1_busy", 64'(bus.p1_busy), 64'd0);
    bus.p0_rd = 1'b0;
    #1;

    // DMA write through WAIT; leaves rr pointing at the CPU.
    cyc(1);
    mode = 1;
    bus.p1_addr = 23'h002000; bus.p1_wdata = 16'hABCD; bus.p1_wr = 1'b1;
    push_cmd(1'b1, 23'h002000, 16'hABCD);
    push_done(PORT_DMA, 1'b0, 1'b0, 32'h0);
    wait_ndone(2, 30, "t1b");
    bus.p1_wr = 1'b0;

    // Simultaneous writes with rr at the CPU.
    cyc(1);
    mode = 0;
    bus.p0_addr = 23'h000010; bus.p0_wdata = 16'h1111; bus.p0_wr = 1'b1;
    bus.p1_addr = 23'h000020; bus.p1_wdata = 16'h2222; bus.p1_wr = 1'b1;
    push_cmd(1'b1, 23'h000010, 16'h1111);
    push_cmd(1'b1, 23'h000020, 16'h2222);
    push_done(PORT_CPU, 1'b0, 1'b0, 32'h0);
    push_done(PORT_DMA, 1'b0, 1'b0, 32'h0);
    wait_ndone(3, 20, "t2_first");
    bus.p0_wr = 1'b0;
    wait_ndone(4, 20, "t2_second");
    bus.p1_wr = 1'b0;

    // Both ports hold reads continuously: eight grants alternating from the CPU.
    cyc(1);
    ctl_rdata = 32'hC0DE0001;
    bus.p0_addr = 23'h000300; bus.p0_wdata = 16'h0300; bus.p0_rd = 1'b1;
    bus.p1_addr = 23'h000400; bus.p1_wdata = 16'h0400; bus.p1_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        push_cmd(1'b0, 23'h000300, 16'h0300);
        push_done(PORT_CPU, 1'b0, 1'b1, 32'hC0DE0001);
      end else begin
        push_cmd(1'b0, 23'h000400, 16'h0400);
        push_done(PORT_DMA, 1'b0, 1'b1, 32'hC0DE0001);
      end
    end
    wait_ndone(12, 100, "t3");
    bus.p0_rd = 1'b0;
    bus.p1_rd = 1'b0;

    // Controller busy holds off the grant.
    cyc(1);
    ctl_rdata = 32'h0BADF00D;
    bus.sd_busy = 1'b1;
    bus.p1_addr = 23'h000700; bus.p1_wdata = 16'h0700; bus.p1_rd = 1'b1;
    push_cmd(1'b0, 23'h000700, 16'h0700);
    push_done(PORT_DMA, 1'b0, 1'b1, 32'h0BADF00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clki);
      chk("t4_held_off", 64'(bus.sd_read), 64'd0);
    end
    cyc(1);
    bus.sd_busy = 1'b0;
    @(negedge clki);
    chk("t4_not_before_edge", 64'(bus.sd_read), 64'd0);
    @(negedge clki);
    chk("t4_grant", 64'(bus.sd_read), 64'd1);
    wait_ndone(13, 20, "t4");
    bus.p1_rd = 1'b0;

    // Timeout: cack but no ready.
    cyc(1);
    mode = 2;
    bus.p0_addr = 23'h000500; bus.p0_wdata = 16'h0500; bus.p0_rd = 1'b1;
    push_cmd(1'b0, 23'h000500, 16'h0500);
    push_done(PORT_CPU, 1'b1, 1'b1, 32'h0);
    @(negedge clki);
    @(negedge clki);
    chk("t5_strobe", 64'(bus.sd_read), 64'd1);
    cnt = 0;
    while (!bus.err && cnt < int'(TMO) + 20) begin
      @(negedge clki);
      cnt++;
    end
    chk("t5_timeout_cycles", 64'(cnt), 64'(TMO));
    chk("t5_done_with_err", 64'(bus.p0_done), 64'd1);
    bus.p0_rd = 1'b0;
    #1;
    cyc(1);
    mode = 0;
    ctl_rdata = 32'h13579BDF;
    bus.p1_addr = 23'h000510; bus.p1_wdata = 16'h0510; bus.p1_rd = 1'b1;
    push_cmd(1'b0, 23'h000510, 16'h0510);
    push_done(PORT_DMA, 1'b0, 1'b1, 32'h13579BDF);
    wait_ndone(15, 20, "t5_next");
    bus.p1_rd = 1'b0;

    // Reset during WAIT, then the still-pending read completes.
    cyc(1);
    mode = 1;
    ctl_rdata = 32'h12345678;
    bus.p0_addr = 23'h000600; bus.p0_wdata = 16'h6666; bus.p0_rd = 1'b1;
    push_cmd(1'b0, 23'h000600, 16'h6666);
    @(negedge clki);
    @(negedge clki);
    chk("t6_strobe", 64'(bus.sd_read), 64'd1);
    @(posedge clki);
    #2;
    rst_in = 1'b0;
    #1;
    chk("t6_rst_sd_read", 64'(bus.sd_read), 64'd0);
    chk("t6_rst_sd_addr", 64'(bus.sd_addr), 64'd0);
    chk("t6_rst_sd_wdata", 64'(bus.sd_wdata), 64'd0);
    chk("t6_rst_p1_rdata", 64'(bus.p1_rdata), 64'd0);
    chk("t6_rst_p0_done", 64'(bus.p0_done), 64'd0);
    chk("t6_rst_err", 64'(bus.err), 64'd0);
    shadow0 = '0;
    shadow1 = '0;
    cyc(2);
    rst_in = 1'b1;
    push_cmd(1'b0, 23'h000600, 16'h6666);
    push_done(PORT_CPU, 1'b0, 1'b1, 32'h12345678);
    wait_ndone(16, 30, "t6_after_reset");
    bus.p0_rd = 1'b0;

    cyc(4);
    chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
    chk("done_total", 64'(ndone), 64'd16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 23, SDRAM word-address width on all ports.
REQ-002 Parameter TIMEOUT, default 1023, max cycles in WAIT before abort; 10-bit counter.
REQ-003 Port clki  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_in  in  1  reset, asynchronous, active-low.
REQ-005 Ports p0_rd, p0_wr  in  1 each  requester 0 (CPU) read/write request; level, held until p0_done.
REQ-006 Ports p0_addr  in  ADDR_W, p0_wdata  in  16  requester 0 address and write data.
REQ-007 Ports p0_rdata  out  32, p0_done  out  1, p0_busy  out  1  read data, one-cycle completion pulse, pending flag.
REQ-008 Ports p1_rd, p1_wr, p1_addr, p1_wdata, p1_rdata, p1_done, p1_busy  identical to port 0, requester 1 (DMA).
REQ-009 Ports sd_read, sd_write  out  1 each  command strobes to SDRAM controller.
REQ-010 Ports sd_addr  out  ADDR_W, sd_wdata  out  16  latched command address and data.
REQ-011 Ports sd_busy, sd_cack, sd_ready  in  1 each  controller busy, command accepted, access complete.
REQ-012 Port sd_rdata  in  32  controller read data, valid while sd_ready high.
REQ-013 Port err  out  1  one-cycle pulse on timeout abort.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, DONE; one access outstanding at a time.
REQ-015 IDLE: a port requests when rd|wr high; with sd_busy low, grant taken on that edge, go to ISSUE; with sd_busy high, stay IDLE.
REQ-016 Only one port requesting -> it wins; both requesting -> port selected by round-robin pointer rr.
REQ-017 rr points to the non-granted port after every grant; rr resets to port 0.
REQ-018 At grant: latch addr, wdata, op (wr has precedence if rd and wr both high), granted port index.
REQ-019 ISSUE: sd_read (op=read) or sd_write (op=write) held high, sd_addr/sd_wdata driven from latches, until a cycle with sd_cack high; then go to WAIT, strobe low next cycle.
REQ-020 sd_cack and sd_ready high in same ISSUE cycle -> go directly to DONE, capture sd_rdata.
REQ-021 WAIT: on sd_ready high capture sd_rdata (reads only; writes leave p*_rdata unchanged) and go to DONE.
REQ-022 DONE: granted port's p*_done high exactly one cycle, p*_rdata updated from capture; return to IDLE next edge.
REQ-023 Minimum latency: request sampled at edge N, strobe high after N, done high after edge N+2 if cack and ready arrive in first ISSUE cycle.
REQ-024 Requester may not re-request in its done cycle; request held at done cycle is treated as new request in IDLE the cycle after.
REQ-025 p*_busy = request pending (rd|wr high) and done not yet pulsed for it; combinational from request and FSM.
REQ-026 Timeout counter cleared on entering ISSUE, increments each cycle in ISSUE/WAIT; reaching TIMEOUT -> err pulse, granted port's done pulse, p*_rdata = 0, next state IDLE.
REQ-027 Request dropped by requester mid-access: access still completes to controller; done still pulsed.
REQ-028 Non-granted port's outputs unchanged during another port's access.

Reset
REQ-029 rst_in low: state IDLE, rr=0, sd_read=sd_write=0, sd_addr=0, sd_wdata=0, p0/p1_rdata=0, p0/p1_done=0, err=0, timeout counter=0, immediately and asynchronously.
REQ-030 Reset mid-access abandons it; no done pulse; controller sees strobe fall asynchronously.
REQ-031 Reset release: first grant evaluated on first clki edge with rst_in high.

Structure
REQ-032 Shared package holds FSM state encoding (2-bit), port-index constants PORT_CPU=0, PORT_DMA=1, default ADDR_W and TIMEOUT.
REQ-033 One sub-module, rr_arbiter2: two request inputs plus pointer in, one-hot grant out; rest in sdram_arbiter.

Verification
REQ-034 p0_rd, addr 0x000100, controller cack+ready one cycle after strobe, sd_rdata 0xDEADBEEF -> p0_rdata=0xDEADBEEF, one p0_done pulse, p1 untouched.
REQ-035 p0_wr and p1_wr same edge, wdata 0x1111/0x2222, rr=0 -> sd_wdata 0x1111 first then 0x2222; each port exactly one done.
REQ-036 Both ports continuously requesting 8 accesses -> grants alternate 0,1,0,1...; neither starved.
REQ-037 sd_busy high 5 cycles with p1_rd pending -> no strobe until sd_busy low; grant next edge.
REQ-038 Controller never asserts sd_ready after cack -> err pulse and p*_done pulse at TIMEOUT cycles, p*_rdata=0, FSM IDLE, next request serviced.
REQ-039 rst_in low during WAIT -> all outputs to REQ-029 values with no clock; after release, pending p0_rd completes normally.
